var_lane_fifo: RTL and testbench
================================

Name: var_lane_fifo

Overview:
- Variable-lane FIFO, next generation of the team's variable-width lane buffer.
- Each accepted beat pushes 0..InLanes contiguous elements taken from any lane offset.
- Each accepted beat pops 0..OutLanes elements placed at any output lane offset.
- Adds independent in/out lane counts, non-power-of-2 depth, synchronous flush, almost-full/empty flags and zeroed unused output lanes.
- Sits between packet (un)packers and fixed-width datapaths.

Parameters:
- ElemWidth, 8, bits per element.
- InLanes, 4, input lanes per beat (>=2).
- OutLanes, 4, output lanes per beat (>=2).
- FifoDepth, 12, storage elements; any value >= max(InLanes,OutLanes).
- AlmostFullTh, 10, almost_full_o asserted when count_o >= AlmostFullTh.
- AlmostEmptyTh, 2, almost_empty_o asserted when count_o <= AlmostEmptyTh.

Ports:
- clk_i  in  1  clock.
- arst_ni  in  1  async reset, active-low.
- flush_i  in  1  sync clear of contents.
- in_num_i  in  $clog2(InLanes+1)  elements to push.
- in_start_i  in  $clog2(InLanes)  first input lane used.
- in_data_i  in  InLanes*ElemWidth  packed input lanes.
- in_valid_i  in  1  push request.
- in_ready_o  out  1  push accepted when valid.
- in_req_err_o  out  1  in_start_i+in_num_i > InLanes.
- out_num_i  in  $clog2(OutLanes+1)  elements to pop.
- out_start_i  in  $clog2(OutLanes)  first output lane filled.
- out_data_o  out  OutLanes*ElemWidth  packed output lanes.
- out_valid_o  out  1  pop data available.
- out_ready_i  in  1  pop request.
- out_req_err_o  out  1  out_start_i+out_num_i > OutLanes.
- count_o  out  $clog2(FifoDepth+1)  stored elements.
- space_o  out  $clog2(FifoDepth+1)  FifoDepth-count_o.
- almost_full_o  out  1  threshold flag.
- almost_empty_o  out  1  threshold flag.

Behaviour:
- Clock clk_i; reset arst_ni, asynchronous, active-low.
- Reset values: wr_ptr, rd_ptr, count_o = 0; space_o = FifoDepth; almost_empty_o = 1; almost_full_o = (AlmostFullTh==0). Memory is not reset.
- Pointer width $clog2(FifoDepth). Wrap: p+n; if result >= FifoDepth, subtract FifoDepth (single subtract is sufficient since n <= FifoDepth). Sum computed one bit wider.
- in_ready_o = !flush_i & !in_req_err_o & (space_o >= in_num_i). Uses registered space only; a same-cycle pop gives no credit.
- out_valid_o = !flush_i & !out_req_err_o & (count_o >= out_num_i).
- Push handshake (in_valid_i & in_ready_o):
  - mem[wrap(wr_ptr+k)] <= in_data_i[in_start_i+k] for k < in_num_i.
  - wr_ptr <= wrap(wr_ptr+in_num_i).
- Combinational read path:
  - out_data_o[out_start_i+k] = mem[wrap(rd_ptr+k)] for k < out_num_i.
  - All other output lanes = 0.
  - out_data_o is valid whenever out_valid_o is high.
- Pop handshake: rd_ptr <= wrap(rd_ptr+out_num_i).
- Count: count_o <= count_o + pushed - popped. Simultaneous push and pop are legal. Pushed data is visible to a pop from the next cycle (zero-latency bypass is not provided).
- num = 0: handshake completes, no state change. num = 0 with start = any value is never an error.
- Full (space_o < in_num_i): in_ready_o low and no write. Empty (count_o < out_num_i): out_valid_o low.
- Flush: next edge sets pointers and count to 0. Flush overrides any push or pop in the same cycle; ready/valid are forced low while flush_i is high.
- Reset mid-transfer: the transfer is dropped; state returns to its reset values.
- Flags and space_o are derived combinationally from registered count_o.

Optional Feature:
- Macro: VAR_LANE_FIFO_WATERMARK_EN.
- When defined:
  - Adds output watermark_o, $clog2(FifoDepth+1) bits, registered: the maximum count_o reached since reset or flush. Cleared to 0 by reset and flush.
  - Adds output overflow_try_o, 1 bit, sticky: set when in_valid_i & !in_ready_o & !in_req_err_o & !flush_i. Cleared only by flush or reset.
- When undefined: neither port nor its logic exists.

Decomposition:
- Package var_lane_fifo_pkg:
  - Function wrap_add(ptr, n, depth).
  - Function lane_req_ok(start, num, lanes).
- Sub-module lane_rotator: parametrised combinational lane shift with per-lane enable mask and zero fill. Instantiated twice, once on input alignment and once on output alignment.

Test Plan:
- Defaults apply throughout. First case, at reset: push in_num=3, start=1, data {D,C,B,A} -> mem[0..2] = B,C,D; count_o = 3 next cycle; almost_empty_o falls.
- Pop out_num=2, start=2 from {B,C,D} -> out_data_o = {C,B,0,0} (lane2=B, lane3=C); count_o = 1.
- Push 4 per beat until full at 12 -> count_o reaches 12, in_ready_o drops. Then push num=4 with count 10 -> rejected; pop num=2 alone -> accepted.
- Wrap: wr_ptr=10, push 4 -> writes mem[10], [11], [0], [1]; wr_ptr = 2. Pops retrieve the data in order across the wrap.
- Simultaneous push 3 / pop 4 at count 5 -> count 4. in_start=2, num=3 -> in_req_err_o = 1, in_ready_o = 0, no write.
- Flush with push and pop both valid at count 7 -> count 0, no write. With the macro enabled: watermark_o = 0 after flush.

Source files
------------

// File: rtl/var_lane_fifo_pkg.sv
// -----------------------------------------------------------------------------
// var_lane_fifo_pkg
// Shared helpers for the variable-lane FIFO slice.
//   wrap_add    : circular pointer advance for a non-power-of-2 depth.
//   lane_req_ok : a lane request stays inside the beat.
// No ports (package).
// -----------------------------------------------------------------------------
package var_lane_fifo_pkg;

  // Advance ptr by n positions in a ring of depth entries. The sum is formed
  // in 32 bits, wider than any pointer. Callers guarantee ptr < depth and
  // n <= depth, so a single conditional subtract is enough.
  function automatic int unsigned wrap_add(input int unsigned ptr,
                                           input int unsigned n,
                                           input int unsigned depth);
    int unsigned sum;
    sum = ptr + n;
    if (sum >= depth) begin
      sum = sum - depth;
    end
    return sum;
  endfunction

  // A request of num elements starting at lane start fits in lanes lanes.
  // num = 0 always fits because start is always below lanes.
  function automatic logic lane_req_ok(input int unsigned start,
                                       input int unsigned num,
                                       input int unsigned lanes);
    return (start + num) <= lanes;
  endfunction

endpackage

// File: rtl/var_lane_fifo_lane_rotator.sv
// -----------------------------------------------------------------------------
// lane_rotator
// Combinational lane shifter: dst lane (dst_base_i + k) receives src lane
// (src_base_i + k) for k < num_i. Every other dst lane is driven to zero.
// Ports:
//   src_data_i  SrcLanes*ElemWidth  packed source lanes
//   src_base_i  SrcBaseW            first source lane taken
//   dst_base_i  DstBaseW            first destination lane filled
//   num_i       NumW                number of lanes moved
//   dst_data_o  DstLanes*ElemWidth  packed destination lanes, zero filled
// -----------------------------------------------------------------------------
module lane_rotator
  import var_lane_fifo_pkg::*;
#(
  parameter int ElemWidth = 8,
  parameter int SrcLanes  = 4,
  parameter int DstLanes  = 4,
  parameter int SrcBaseW  = 2,
  parameter int DstBaseW  = 2,
  parameter int NumW      = 3
) (
  input  logic [SrcLanes*ElemWidth-1:0] src_data_i,
  input  logic [SrcBaseW-1:0]           src_base_i,
  input  logic [DstBaseW-1:0]           dst_base_i,
  input  logic [NumW-1:0]               num_i,
  output logic [DstLanes*ElemWidth-1:0] dst_data_o
);

  // Per-lane enable mask: lane is inside the moved window.
  logic [DstLanes-1:0] lane_en;

  for (genvar gi = 0; gi < DstLanes; gi++) begin : g_lane
    int rel_idx;
    int src_idx;
    always_comb begin
      rel_idx     = gi - int'(dst_base_i);
      src_idx     = rel_idx + int'(src_base_i);
      lane_en[gi] = (rel_idx >= 0) && (rel_idx < int'(num_i)) &&
                    (src_idx < SrcLanes);
      dst_data_o[gi*ElemWidth +: ElemWidth] = '0;
      if (lane_en[gi]) begin
        dst_data_o[gi*ElemWidth +: ElemWidth] =
          src_data_i[src_idx*ElemWidth +: ElemWidth];
      end
    end
  end

endmodule

// File: rtl/var_lane_fifo.sv
// -----------------------------------------------------------------------------
// var_lane_fifo
// Variable-lane FIFO: each accepted beat pushes 0..InLanes contiguous
// elements from any input lane offset and pops 0..OutLanes elements placed at
// any output lane offset. Storage depth need not be a power of two.
// Optional build macro VAR_LANE_FIFO_WATERMARK_EN adds watermark_o (peak
// count since reset/flush) and overflow_try_o (sticky rejected-push flag).
// Ports:
//   clk_i, arst_ni          clock, asynchronous active-low reset
//   flush_i                 synchronous clear of contents
//   in_num_i/in_start_i     push element count / first input lane
//   in_data_i, in_valid_i   packed input lanes, push request
//   in_ready_o, in_req_err_o push accepted / illegal lane request
//   out_num_i/out_start_i   pop element count / first output lane
//   out_data_o, out_valid_o packed output lanes (unused lanes zero), data ok
//   out_ready_i, out_req_err_o pop request / illegal lane request
//   count_o, space_o        stored elements / free elements
//   almost_full_o/almost_empty_o threshold flags on count_o
// -----------------------------------------------------------------------------
module var_lane_fifo
  import var_lane_fifo_pkg::*;
#(
  parameter int ElemWidth     = 8,
  parameter int InLanes       = 4,
  parameter int OutLanes      = 4,
  parameter int FifoDepth     = 12,
  parameter int AlmostFullTh  = 10,
  parameter int AlmostEmptyTh = 2
) (
  input  logic                               clk_i,
  input  logic                               arst_ni,
  input  logic                               flush_i,
  input  logic [$clog2(InLanes+1)-1:0]       in_num_i,
  input  logic [$clog2(InLanes)-1:0]         in_start_i,
  input  logic [InLanes*ElemWidth-1:0]       in_data_i,
  input  logic                               in_valid_i,
  output logic                               in_ready_o,
  output logic                               in_req_err_o,
  input  logic [$clog2(OutLanes+1)-1:0]      out_num_i,
  input  logic [$clog2(OutLanes)-1:0]        out_start_i,
  output logic [OutLanes*ElemWidth-1:0]      out_data_o,
  output logic                               out_valid_o,
  input  logic                               out_ready_i,
  output logic                               out_req_err_o,
  output logic [$clog2(FifoDepth+1)-1:0]     count_o,
  output logic [$clog2(FifoDepth+1)-1:0]     space_o,
  output logic                               almost_full_o,
  output logic                               almost_empty_o
`ifdef VAR_LANE_FIFO_WATERMARK_EN
  ,
  output logic [$clog2(FifoDepth+1)-1:0]     watermark_o,
  output logic                               overflow_try_o
`endif
);

  localparam int PtrW    = $clog2(FifoDepth);
  localparam int CntW    = $clog2(FifoDepth+1);
  localparam int InNumW  = $clog2(InLanes+1);
  localparam int OutNumW = $clog2(OutLanes+1);
  localparam int InSW    = $clog2(InLanes);
  localparam int OutSW   = $clog2(OutLanes);

  // Element storage; not reset, contents only meaningful below count.
  logic [ElemWidth-1:0] mem_reg [FifoDepth];

  logic [PtrW-1:0] wr_ptr_reg, wr_ptr_next;
  logic [PtrW-1:0] rd_ptr_reg, rd_ptr_next;
  logic [CntW-1:0] count_reg, count_next;
  logic            push, pop;

  logic [InLanes*ElemWidth-1:0]  in_aligned;  // input elements packed at lane 0
  logic [OutLanes*ElemWidth-1:0] rd_window;   // next OutLanes elements from rd_ptr

  // ---------------------------------------------------------------- status
  assign count_o        = count_reg;
  assign space_o        = CntW'(FifoDepth) - count_reg;
  assign almost_full_o  = int'(count_reg) >= AlmostFullTh;
  assign almost_empty_o = int'(count_reg) <= AlmostEmptyTh;

  assign in_req_err_o  = !lane_req_ok(32'(in_start_i), 32'(in_num_i), InLanes);
  assign out_req_err_o = !lane_req_ok(32'(out_start_i), 32'(out_num_i), OutLanes);

  // Space is the registered value: a pop in the same cycle gives no credit.
  assign in_ready_o  = !flush_i && !in_req_err_o &&
                       (int'(space_o) >= int'(in_num_i));
  assign out_valid_o = !flush_i && !out_req_err_o &&
                       (int'(count_reg) >= int'(out_num_i));

  assign push = in_valid_i && in_ready_o;
  assign pop  = out_valid_o && out_ready_i;

  // ---------------------------------------------------------- input align
  lane_rotator #(
    .ElemWidth (ElemWidth),
    .SrcLanes  (InLanes),
    .DstLanes  (InLanes),
    .SrcBaseW  (InSW),
    .DstBaseW  (1),
    .NumW      (InNumW)
  ) u_in_rot (
    .src_data_i (in_data_i),
    .src_base_i (in_start_i),
    .dst_base_i (1'b0),
    .num_i      (in_num_i),
    .dst_data_o (in_aligned)
  );

  // --------------------------------------------------------- output align
  for (genvar gi = 0; gi < OutLanes; gi++) begin : g_rd
    assign rd_window[gi*ElemWidth +: ElemWidth] =
      mem_reg[PtrW'(wrap_add(32'(rd_ptr_reg), gi, FifoDepth))];
  end

  lane_rotator #(
    .ElemWidth (ElemWidth),
    .SrcLanes  (OutLanes),
    .DstLanes  (OutLanes),
    .SrcBaseW  (1),
    .DstBaseW  (OutSW),
    .NumW      (OutNumW)
  ) u_out_rot (
    .src_data_i (rd_window),
    .src_base_i (1'b0),
    .dst_base_i (out_start_i),
    .num_i      (out_num_i),
    .dst_data_o (out_data_o)
  );

  // ---------------------------------------------------------- next state
  always_comb begin
    wr_ptr_next = wr_ptr_reg;
    rd_ptr_next = rd_ptr_reg;
    count_next  = count_reg;
    if (flush_i) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = PtrW'(wrap_add(32'(wr_ptr_reg), 32'(in_num_i), FifoDepth));
      end
      if (pop) begin
        rd_ptr_next = PtrW'(wrap_add(32'(rd_ptr_reg), 32'(out_num_i), FifoDepth));
      end
      count_next = CntW'(int'(count_reg)
                         + (push ? int'(in_num_i)  : 0)
                         - (pop  ? int'(out_num_i) : 0));
    end
  end

  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  // Element k of an accepted push lands k slots past wr_ptr (push is already
  // blocked during flush through in_ready_o).
  always_ff @(posedge clk_i) begin
    if (push) begin
      for (int k = 0; k < InLanes; k++) begin
        if (k < int'(in_num_i)) begin
          mem_reg[PtrW'(wrap_add(32'(wr_ptr_reg), k, FifoDepth))] <=
            in_aligned[k*ElemWidth +: ElemWidth];
        end
      end
    end
  end

`ifdef VAR_LANE_FIFO_WATERMARK_EN
  logic [CntW-1:0] watermark_reg;
  logic            overflow_try_reg;

  assign watermark_o    = watermark_reg;
  assign overflow_try_o = overflow_try_reg;

  // Watermark follows the count that is about to be registered, so it never
  // lags count_o.
  always_ff @(posedge clk_i or negedge arst_ni) begin
    if (!arst_ni) begin
      watermark_reg    <= '0;
      overflow_try_reg <= 1'b0;
    end else if (flush_i) begin
      watermark_reg    <= '0;
      overflow_try_reg <= 1'b0;
    end else begin
      if (count_next > watermark_reg) begin
        watermark_reg <= count_next;
      end
      if (in_valid_i && !in_ready_o && !in_req_err_o) begin
        overflow_try_reg <= 1'b1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_var_lane_fifo.sv
// -----------------------------------------------------------------------------
// tb_var_lane_fifo
// Directed walk through the main scenarios followed by a random phase, all
// checked against a queue-based model of the FIFO contents.
// -----------------------------------------------------------------------------
module tb_var_lane_fifo;

  localparam int EW    = 8;
  localparam int IL    = 4;
  localparam int OL    = 4;
  localparam int DEPTH = 12;
  localparam int AFT   = 10;
  localparam int AET   = 2;

  logic        clk_i   = 1'b0;
  logic        arst_ni = 1'b1;
  logic        flush_i;
  logic [2:0]  in_num_i;
  logic [1:0]  in_start_i;
  logic [31:0] in_data_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic        in_req_err_o;
  logic [2:0]  out_num_i;
  logic [1:0]  out_start_i;
  logic [31:0] out_data_o;
  logic        out_valid_o;
  logic        out_ready_i;
  logic        out_req_err_o;
  logic [3:0]  count_o;
  logic [3:0]  space_o;
  logic        almost_full_o;
  logic        almost_empty_o;
`ifdef VAR_LANE_FIFO_WATERMARK_EN
  logic [3:0]  watermark_o;
  logic        overflow_try_o;
`endif

  var_lane_fifo #(
    .ElemWidth(EW), .InLanes(IL), .OutLanes(OL), .FifoDepth(DEPTH),
    .AlmostFullTh(AFT), .AlmostEmptyTh(AET)
  ) dut (
    .clk_i          (clk_i),
    .arst_ni        (arst_ni),
    .flush_i        (flush_i),
    .in_num_i       (in_num_i),
    .in_start_i     (in_start_i),
    .in_data_i      (in_data_i),
    .in_valid_i     (in_valid_i),
    .in_ready_o     (in_ready_o),
    .in_req_err_o   (in_req_err_o),
    .out_num_i      (out_num_i),
    .out_start_i    (out_start_i),
    .out_data_o     (out_data_o),
    .out_valid_o    (out_valid_o),
    .out_ready_i    (out_ready_i),
    .out_req_err_o  (out_req_err_o),
    .count_o        (count_o),
    .space_o        (space_o),
    .almost_full_o  (almost_full_o),
    .almost_empty_o (almost_empty_o)
`ifdef VAR_LANE_FIFO_WATERMARK_EN
    ,
    .watermark_o    (watermark_o),
    .overflow_try_o (overflow_try_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  int vectors     = 0;
  int miscompares = 0;

  // Model: the stored elements in FIFO order, plus the optional extras.
  byte unsigned q[$];
  int           wm_model  = 0;
  bit           ovf_model = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit fl, input bit iv, input int inn, input int ins,
                       input logic [31:0] d, input bit ordy, input int onn,
                       input int ons);
    flush_i     = fl;
    in_valid_i  = iv;
    in_num_i    = 3'(inn);
    in_start_i  = 2'(ins);
    in_data_i   = d;
    out_ready_i = ordy;
    out_num_i   = 3'(onn);
    out_start_i = 2'(ons);
  endtask

  // Check every output against the model for the driven inputs, then take one
  // clock edge and advance the model.
  task automatic step();
    int          cnt;
    int          inn, ins, onn, ons;
    bit          ierr, oerr, irdy, ovld;
    logic [31:0] exp_data;
    #1;
    cnt  = q.size();
    inn  = int'(in_num_i);
    ins  = int'(in_start_i);
    onn  = int'(out_num_i);
    ons  = int'(out_start_i);
    ierr = (ins + inn) > IL;
    oerr = (ons + onn) > OL;
    irdy = !flush_i && !ierr && ((DEPTH - cnt) >= inn);
    ovld = !flush_i && !oerr && (cnt >= onn);
    check("count",        64'(count_o),        64'(cnt));
    check("space",        64'(space_o),        64'(DEPTH - cnt));
    check("almost_full",  64'(almost_full_o),  64'(cnt >= AFT));
    check("almost_empty", 64'(almost_empty_o), 64'(cnt <= AET));
    check("in_req_err",   64'(in_req_err_o),   64'(ierr));
    check("out_req_err",  64'(out_req_err_o),  64'(oerr));
    check("in_ready",     64'(in_ready_o),     64'(irdy));
    check("out_valid",    64'(out_valid_o),    64'(ovld));
    if (ovld) begin
      exp_data = '0;
      for (int k = 0; k < onn; k++) exp_data[(ons+k)*EW +: EW] = q[k];
      check("out_data", 64'(out_data_o), 64'(exp_data));
    end
`ifdef VAR_LANE_FIFO_WATERMARK_EN
    check("watermark",    64'(watermark_o),    64'(wm_model));
    check("overflow_try", 64'(overflow_try_o), 64'(ovf_model));
`endif
    @(posedge clk_i);
    if (flush_i) begin
      q.delete();
      wm_model  = 0;
      ovf_model = 1'b0;
    end else begin
      if (in_valid_i && !irdy && !ierr) ovf_model = 1'b1;
      if (ovld && out_ready_i) repeat (onn) void'(q.pop_front());
      if (in_valid_i && irdy)
        for (int k = 0; k < inn; k++) q.push_back(in_data_i[(ins+k)*EW +: EW]);
      if (q.size() > wm_model) wm_model = q.size();
    end
    #1;
  endtask

  initial begin
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
    #2 arst_ni = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_count",        64'(count_o),        64'd0);
    check("rst_space",        64'(space_o),        64'(DEPTH));
    check("rst_almost_empty", 64'(almost_empty_o), 64'd1);
    check("rst_almost_full",  64'(almost_full_o),  64'd0);
    arst_ni = 1'b1;

    // Push 3 from lane 1 of {D,C,B,A}: stores B,C,D.
    drive(0, 1, 3, 1, 32'hDDCCBBAA, 0, 0, 0); step();
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0);
    #1;
    check("tp_push_count", 64'(count_o),        64'd3);
    check("tp_push_ae",    64'(almost_empty_o), 64'd0);

    // Pop 2 into lanes 2..3.
    drive(0, 0, 0, 0, 32'h0, 1, 2, 2);
    #1;
    check("tp_pop_data", 64'(out_data_o), 64'h00000000CCBB0000);
    step();
    check("tp_pop_count", 64'(count_o), 64'd1);

    // Fill to 12.
    drive(0, 1, 4, 0, 32'h13121110, 0, 0, 0); step();
    drive(0, 1, 4, 0, 32'h17161514, 0, 0, 0); step();
    drive(0, 1, 3, 1, 32'h1A191800, 0, 0, 0); step();
    check("tp_full_count", 64'(count_o), 64'd12);
    drive(0, 1, 4, 0, 32'hEEEEEEEE, 0, 0, 0);
    #1;
    check("tp_full_ready", 64'(in_ready_o), 64'd0);
    step();
    drive(0, 1, 1, 0, 32'hEEEEEEEE, 0, 0, 0); step();
    drive(0, 0, 0, 0, 32'h0, 1, 2, 0);        step();
    // Count 10: push 4 rejected, pop 2 accepted.
    drive(0, 1, 4, 0, 32'hEEEEEEEE, 1, 2, 1);
    #1;
    check("tp_c10_ready", 64'(in_ready_o),  64'd0);
    check("tp_c10_valid", 64'(out_valid_o), 64'd1);
    step();
    check("tp_c10_count", 64'(count_o), 64'd8);
    drive(0, 0, 0, 0, 32'h0, 1, 4, 0); step();
    drive(0, 0, 0, 0, 32'h0, 1, 4, 0); step();
    drive(1, 0, 0, 0, 32'h0, 0, 0, 0); step();

    // Wrap: bring wr_ptr to 10 then push 4 across the end of storage.
    drive(0, 1, 4, 0, 32'h23222120, 0, 0, 0); step();
    drive(0, 1, 4, 0, 32'h27262524, 0, 0, 0); step();
    drive(0, 1, 2, 2, 32'h29280000, 0, 0, 0); step();
    drive(0, 0, 0, 0, 32'h0, 1, 4, 0);        step();
    drive(0, 0, 0, 0, 32'h0, 1, 4, 0);        step();
    drive(0, 1, 4, 0, 32'h33323130, 0, 0, 0); step();
    drive(0, 0, 0, 0, 32'h0, 1, 4, 0);        step();
    drive(0, 0, 0, 0, 32'h0, 1, 2, 1);        step();
    check("tp_wrap_count", 64'(count_o), 64'd0);

    // Simultaneous push 3 / pop 4 at count 5.
    drive(0, 1, 4, 0, 32'h43424140, 0, 0, 0); step();
    drive(0, 1, 1, 3, 32'h44000000, 0, 0, 0); step();
    drive(0, 1, 3, 0, 32'h00474645, 1, 4, 0); step();
    check("tp_sim_count", 64'(count_o), 64'd4);
    // Illegal input lane request.
    drive(0, 1, 3, 2, 32'h55555555, 0, 0, 0);
    #1;
    check("tp_err_flag",  64'(in_req_err_o), 64'd1);
    check("tp_err_ready", 64'(in_ready_o),   64'd0);
    step();
    check("tp_err_count", 64'(count_o), 64'd4);

    // Flush at count 7 with push and pop both requested.
    drive(0, 1, 3, 0, 32'h004A4948, 0, 0, 0); step();
    drive(1, 1, 4, 0, 32'h66666666, 1, 2, 0); step();
    check("tp_flush_count", 64'(count_o), 64'd0);
`ifdef VAR_LANE_FIFO_WATERMARK_EN
    check("tp_flush_wm", 64'(watermark_o), 64'd0);
`endif

    // Random phase.
    for (int i = 0; i < 400; i++) begin
      drive(($urandom_range(0, 31) == 0), $urandom_range(0, 1),
            $urandom_range(0, 4), $urandom_range(0, 3), $urandom,
            $urandom_range(0, 1), $urandom_range(0, 4), $urandom_range(0, 3));
      step();
    end

    // Reset in the middle of a push: transfer dropped, state back to reset.
    drive(0, 1, 2, 0, 32'h00007776, 1, 1, 0);
    #2 arst_ni = 1'b0;
    #1;
    check("midrst_count", 64'(count_o), 64'd0);
    check("midrst_space", 64'(space_o), 64'(DEPTH));
    q.delete();
    wm_model  = 0;
    ovf_model = 1'b0;
    @(posedge clk_i);
    #1 arst_ni = 1'b1;
    drive(0, 0, 0, 0, 32'h0, 0, 0, 0); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
